// File: rtl/bus_tgen_pkg.sv
// Shared types and constants for the bus traffic generator (state encoding,
// LFSR feedback taps, bus mode values).
package bus_tgen_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GEN,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CHECK,
    ST_GAP,
    ST_DONE
  } tgen_state_e;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_tgen_lfsr.sv
// 16-bit Fibonacci LFSR with seed load on synchronous reset and step enable.
module bus_tgen_lfsr
  import bus_tgen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/bus_traffic_gen.sv
// Write-then-readback bus BIST master for one d_* port.
// Optional macro BUS_TGEN_RANDOM_GAP_EN inserts 0-7 idle cycles between pairs.
module bus_traffic_gen
  import bus_tgen_pkg::*;
#(
  parameter int          ADDR_WIDTH            = 16,
  parameter int          DATA_WIDTH            = 8,
  parameter int          SLAVE_MEM_ADDR_WIDTH  = 12,
  parameter int          NUM_SLAVES            = 3,
  parameter int          SLAVE0_MEM_ADDR_WIDTH = 11,
  parameter int          NUM_TXN               = 16,
  parameter logic [15:0] LFSR_SEED             = 16'hACE1,
  parameter int          TIMEOUT_CYCLES        = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [15:0]           txn_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [ADDR_WIDTH-1:0] d_addr,
  output logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_mode,
  output logic                  d_valid,
  input  logic                  d_ready
);

  localparam int ID_W  = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [SLAVE_MEM_ADDR_WIDTH-1:0] SLAVE0_MASK =
    SLAVE_MEM_ADDR_WIDTH'((1 << SLAVE0_MEM_ADDR_WIDTH) - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  tgen_state_e             state_q, state_d;
  logic [15:0]             lfsr_q;
  logic                    lfsr_en;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    mode_q, mode_d;
  logic                    seen_low_q, seen_low_d;
  logic                    tmo_flag_q, tmo_flag_d;
  logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    tmo_expired;
  logic [15:0]             err_q, err_d;
  logic [15:0]             txn_q, txn_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]   fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0]   fail_act_q, fail_act_d;
`ifdef BUS_TGEN_RANDOM_GAP_EN
  logic [2:0]              gap_q, gap_d;
`endif

  logic [ID_W-1:0]                 gen_id;
  logic [SLAVE_MEM_ADDR_WIDTH-1:0] gen_off;

  // The LFSR steps on the edge that enters GEN, so GEN already sees the fresh value.
  bus_tgen_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (lfsr_en),
    .state_o (lfsr_q)
  );

  always_comb begin
    gen_id = lfsr_q[15 -: ID_W];
    if (int'(gen_id) >= NUM_SLAVES) begin
      gen_id = '0;
    end
    gen_off = lfsr_q[SLAVE_MEM_ADDR_WIDTH-1:0];
    if (gen_id == '0) begin
      gen_off = gen_off & SLAVE0_MASK;
    end
  end

  assign tmo_expired = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d     = state_q;
    lfsr_en     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mode_d      = mode_q;
    seen_low_d  = seen_low_q;
    tmo_flag_d  = tmo_flag_q;
    err_d       = err_q;
    txn_d       = txn_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
`ifdef BUS_TGEN_RANDOM_GAP_EN
    gap_d       = gap_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_GEN;
          lfsr_en     = 1'b1;
          err_d       = '0;
          txn_d       = '0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
        end
      end
      ST_GEN: begin
        addr_d     = {gen_id, gen_off};
        wdata_d    = lfsr_q[DATA_WIDTH-1:0] ^ txn_q[DATA_WIDTH-1:0];
        mode_d     = MODE_WRITE;
        tmo_flag_d = 1'b0;
        state_d    = ST_WR_REQ;
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (d_ready) begin
          seen_low_d = 1'b0;
          state_d    = (state_q == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
        end else if (tmo_expired) begin
          tmo_flag_d = 1'b1;
          state_d    = ST_CHECK;
        end
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        // Completion is a busy-then-idle pulse on d_ready after the accept.
        if (seen_low_q && d_ready) begin
          if (state_q == ST_WR_WAIT) begin
            mode_d  = MODE_READ;
            state_d = ST_RD_REQ;
          end else begin
            rdata_d = d_rdata;
            state_d = ST_CHECK;
          end
        end else begin
          if (!d_ready) begin
            seen_low_d = 1'b1;
          end
          if (tmo_expired) begin
            tmo_flag_d = 1'b1;
            state_d    = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        txn_d = sat_inc16(txn_q);
        if (tmo_flag_q || (rdata_q != wdata_q)) begin
          err_d = sat_inc16(err_q);
          if (err_q == '0) begin
            fail_addr_d = addr_q;
            fail_exp_d  = wdata_q;
            fail_act_d  = tmo_flag_q ? '0 : rdata_q;
          end
        end
        if (txn_d == 16'(NUM_TXN)) begin
          state_d = ST_DONE;
        end else begin
`ifdef BUS_TGEN_RANDOM_GAP_EN
          if (lfsr_q[2:0] != 3'd0) begin
            gap_d   = lfsr_q[2:0];
            state_d = ST_GAP;
          end else begin
            lfsr_en = 1'b1;
            state_d = ST_GEN;
          end
`else
          lfsr_en = 1'b1;
          state_d = ST_GEN;
`endif
        end
      end
`ifdef BUS_TGEN_RANDOM_GAP_EN
      ST_GAP: begin
        if (gap_q <= 3'd1) begin
          lfsr_en = 1'b1;
          state_d = ST_GEN;
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (tmo_expired) begin
      tmo_cnt_d = tmo_cnt_q;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mode_q      <= 1'b0;
      seen_low_q  <= 1'b0;
      tmo_flag_q  <= 1'b0;
      tmo_cnt_q   <= '0;
      err_q       <= '0;
      txn_q       <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
`ifdef BUS_TGEN_RANDOM_GAP_EN
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mode_q      <= mode_d;
      seen_low_q  <= seen_low_d;
      tmo_flag_q  <= tmo_flag_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      txn_q       <= txn_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
`ifdef BUS_TGEN_RANDOM_GAP_EN
      gap_q       <= gap_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign txn_count = txn_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
  assign d_addr    = addr_q;
  assign d_wdata   = wdata_q;
  assign d_mode    = mode_q;
  assign d_valid   = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);

endmodule

// File: tb/tb_bus_traffic_gen.sv
// Bench for bus_traffic_gen: echo-memory slave with optional read corruption,
// reference address/data sequence computed from the LFSR polynomial.
module tb_bus_traffic_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] err_a, txn_a, err_b, txn_b;
  logic [15:0] fail_addr_a, fail_addr_b;
  logic [7:0]  fail_exp_a, fail_act_a, fail_exp_b, fail_act_b;
  logic [15:0] d_addr_a, d_addr_b;
  logic [7:0]  d_wdata_a, d_wdata_b, d_rdata_a, d_rdata_b;
  logic        d_mode_a, d_mode_b, d_valid_a, d_valid_b, d_ready_a, d_ready_b;

  int n_tests = 0;
  int n_fail  = 0;

  bus_traffic_gen #(.NUM_TXN(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .txn_count(txn_a), .fail_addr(fail_addr_a), .fail_exp(fail_exp_a),
    .fail_act(fail_act_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a), .d_rdata(d_rdata_a),
    .d_mode(d_mode_a), .d_valid(d_valid_a), .d_ready(d_ready_a)
  );

  bus_traffic_gen #(.NUM_TXN(4), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .txn_count(txn_b), .fail_addr(fail_addr_b), .fail_exp(fail_exp_b),
    .fail_act(fail_act_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_rdata(d_rdata_b),
    .d_mode(d_mode_b), .d_valid(d_valid_b), .d_ready(d_ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- slave model for instance A ----------------
  logic [7:0]  mem [0:65535];
  logic [31:0] corrupt;
  bit          lat_rand;
  int          rd_idx;
  logic [15:0] log_addr [$];
  logic        log_mode [$];
  logic [7:0]  log_wd   [$];

  initial begin
    logic        acc, s_rst, s_mode, pend_rd;
    logic [15:0] s_addr;
    logic [7:0]  s_wd, pend;
    int          cnt;
    d_ready_a = 1'b1;
    d_rdata_a = 8'h00;
    cnt = 0; pend = 8'h00; pend_rd = 1'b0;
    forever begin
      @(posedge clk);
      s_rst  = rst;
      acc    = d_valid_a && d_ready_a;
      s_addr = d_addr_a;
      s_mode = d_mode_a;
      s_wd   = d_wdata_a;
      @(negedge clk);
      if (s_rst) begin
        d_ready_a = 1'b1;
        cnt = 0;
      end else if (acc) begin
        log_addr.push_back(s_addr);
        log_mode.push_back(s_mode);
        log_wd.push_back(s_wd);
        if (s_mode) begin
          mem[s_addr] = s_wd;
          pend_rd = 1'b0;
        end else begin
          pend = mem[s_addr] ^ ((rd_idx < 4) ? corrupt[8*rd_idx +: 8] : 8'h00);
          pend_rd = 1'b1;
          rd_idx++;
        end
        d_ready_a = 1'b0;
        cnt = lat_rand ? int'($urandom_range(1, 6)) : 3;
      end else if (!d_ready_a) begin
        cnt--;
        if (cnt <= 0) begin
          d_ready_a = 1'b1;
          d_rdata_a = pend_rd ? pend : 8'($urandom);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] model_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int v, fb;
    v  = int'(x);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 32'hFFFF);
  endfunction

  function automatic logic [15:0] model_addr(input logic [15:0] l);
    int id, off;
    id  = int'(l) / 4096;
    off = int'(l) % 4096;
    if (id >= 3) id = 0;
    if (id == 0) off = off % 2048;
    return 16'(id * 4096 + off);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int c;
    c = 0;
    while (!done_a && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done_in_time"}, 32'(done_a), 32'd1);
  endtask

  // exp_err < 0 means: take the expectation from the reference model.
  task automatic run_a(input string tag, input logic [31:0] masks, input bit rnd,
                       input int exp_err_tbl, input int exp_pass_tbl);
    logic [15:0] ea [4];
    logic [7:0]  ew [4];
    logic [7:0]  mk;
    logic [15:0] fa;
    logic [7:0]  fe, fact;
    int          m_err, exp_err, exp_pass, n;
    m_err = 0; fa = '0; fe = '0; fact = '0;
    for (int p = 0; p < 4; p++) begin
      model_lfsr = lfsr_step(model_lfsr);
      ea[p] = model_addr(model_lfsr);
      ew[p] = model_lfsr[7:0] ^ 8'(p);
      mk = masks[8*p +: 8];
      if (mk != 8'h00) begin
        if (m_err == 0) begin
          fa = ea[p]; fe = ew[p]; fact = ew[p] ^ mk;
        end
        m_err++;
      end
    end
    exp_err  = (exp_err_tbl >= 0) ? exp_err_tbl : m_err;
    exp_pass = (exp_err_tbl >= 0) ? exp_pass_tbl : int'(m_err == 0);
    corrupt  = masks;
    lat_rand = rnd;
    rd_idx   = 0;
    log_addr.delete(); log_mode.delete(); log_wd.delete();
    pulse_start_a();
    wait_done_a(tag);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_err"}, 32'(err_a), 32'(exp_err));
    chk({tag, "_pass"}, 32'(pass_a), 32'(exp_pass));
    chk({tag, "_txn"}, 32'(txn_a), 32'd4);
    chk({tag, "_fail_addr"}, 32'(fail_addr_a), 32'(fa));
    chk({tag, "_fail_exp"}, 32'(fail_exp_a), 32'(fe));
    chk({tag, "_fail_act"}, 32'(fail_act_a), 32'(fact));
    chk({tag, "_accepts"}, 32'(log_mode.size()), 32'd8);
    n = (log_mode.size() < 8) ? log_mode.size() : 8;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_mode"}, 32'(log_mode[i]), 32'((i % 2) == 0));
      chk({tag, "_addr"}, 32'(log_addr[i]), 32'(ea[i/2]));
      if ((i % 2) == 0) chk({tag, "_wdata"}, 32'(log_wd[i]), 32'(ew[i/2]));
      chk({tag, "_id_range"}, 32'(log_addr[i][15:12] <= 4'd2), 32'd1);
      if (log_addr[i][15:12] == 4'd0) chk({tag, "_id0_bit11"}, 32'(log_addr[i][11]), 32'd0);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] masks;
    bit          rnd;
    int          exp_err;
    int          exp_pass;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    logic [31:0] m;
    int          c;
    logic [15:0] first_b;

    vecs[0] = '{"clean",      32'h0000_0000, 1'b0, 0, 1};
    vecs[1] = '{"pair2_bit0", 32'h0001_0000, 1'b0, 1, 0};
    vecs[2] = '{"p0_p3",      32'hFF00_0080, 1'b0, 2, 0};
    vecs[3] = '{"clean_rlat", 32'h0000_0000, 1'b1, 0, 1};
    vecs[4] = '{"all_bad",    32'h0804_0201, 1'b1, 4, 0};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    d_ready_b = 1'b0; d_rdata_b = 8'hA5;
    corrupt = '0; lat_rand = 1'b0; rd_idx = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_txn", 32'(txn_a), 32'd0);
    chk("rst_valid", 32'(d_valid_a), 32'd0);
    chk("rst_bus", {d_addr_a, d_wdata_a, 7'd0, d_mode_a}, 32'd0);
    chk("rst_fail", {fail_addr_a, fail_exp_a, fail_act_a}, 32'd0);
    rst = 1'b0;
    model_lfsr = SEED;

    for (int v = 0; v < 5; v++) begin
      run_a(vecs[v].name, vecs[v].masks, vecs[v].rnd, vecs[v].exp_err, vecs[v].exp_pass);
    end

    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < 4; b++) m[8*b +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      run_a("random", m, 1'b1, -1, 0);
    end

    // Reset in the read-wait of the third pair, then rerun from the seed.
    corrupt = '0; lat_rand = 1'b0; rd_idx = 0;
    log_addr.delete(); log_mode.delete(); log_wd.delete();
    pulse_start_a();
    c = 0;
    while (log_mode.size() < 6 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("midrst_reached_rd", 32'(log_mode.size() >= 6), 32'd1);
    chk("midrst_txn_before", 32'(txn_a), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(d_valid_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_done", 32'(done_a), 32'd0);
    chk("midrst_txn", 32'(txn_a), 32'd0);
    chk("midrst_err", 32'(err_a), 32'd0);
    rst = 1'b0;
    model_lfsr = SEED;
    run_a("after_rst", 32'h0000_0000, 1'b0, 0, 1);

    // Instance B: d_ready stuck low, every write phase times out.
    first_b = model_addr(lfsr_step(SEED));
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    @(negedge clk);
    chk("tmo_valid_up", 32'(d_valid_b), 32'd1);
    chk("tmo_mode_wr", 32'(d_mode_b), 32'd1);
    c = 0;
    while (!done_b && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("tmo_done", 32'(done_b), 32'd1);
    chk("tmo_err", 32'(err_b), 32'd4);
    chk("tmo_txn", 32'(txn_b), 32'd4);
    chk("tmo_pass", 32'(pass_b), 32'd0);
    chk("tmo_valid_down", 32'(d_valid_b), 32'd0);
    chk("tmo_fail_act", 32'(fail_act_b), 32'd0);
    chk("tmo_fail_addr", 32'(fail_addr_b), 32'(first_b));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_traffic_gen.md
Name: bus_traffic_gen

Overview:
- Synthesisable, self-checking traffic generator for one master device port of the system bus (d_* ready/valid interface, mode 0 = read, 1 = write).
- Issues NUM_TXN write-then-readback pairs to LFSR-chosen addresses in mapped slaves and compares read data with written data.
- Reports pass/fail and first-failure details.
- Sits in place of an external device on top-level d1/d2 ports for on-chip bus BIST; one instance per master port.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 8, bus data width.
- SLAVE_MEM_ADDR_WIDTH, 12, slave memory offset width; device id = upper ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH bits.
- NUM_SLAVES, 3, mapped slave ids 0..NUM_SLAVES-1.
- SLAVE0_MEM_ADDR_WIDTH, 11, slave 0 offset width (2K slave).
- NUM_TXN, 16, write/read pairs per run (1..65535).
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.
- TIMEOUT_CYCLES, 255, max wait cycles per bus phase.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a run when idle or done.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or rst.
- pass  out  1  valid when done; 1 = err_count==0.
- err_count  out  16  mismatches plus timeouts.
- txn_count  out  16  completed pairs.
- fail_addr  out  ADDR_WIDTH  address of first failure.
- fail_exp  out  DATA_WIDTH  expected data of first failure.
- fail_act  out  DATA_WIDTH  actual data of first failure.
- d_addr  out  ADDR_WIDTH  bus address.
- d_wdata  out  DATA_WIDTH  write data.
- d_rdata  in  DATA_WIDTH  read data.
- d_mode  out  1  0 = read, 1 = write.
- d_valid  out  1  request valid.
- d_ready  in  1  master port ready.

Behaviour:
- Reset: rst sampled at posedge. All outputs 0; LFSR = LFSR_SEED; state IDLE. rst mid-run aborts on that edge: d_valid 0, no partial result.
- States: IDLE, GEN, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, GAP, DONE.
- IDLE/DONE --start--> GEN. Clears counters and fail_*, sets busy=1, done=0. start in any other state is ignored.
- GEN (1 cycle):
  - Advance LFSR (x^16+x^14+x^13+x^11).
  - id = lfsr top bits; if id>=NUM_SLAVES, id=0.
  - Offset = lfsr low SLAVE_MEM_ADDR_WIDTH bits, masked to SLAVE0_MEM_ADDR_WIDTH bits when id==0. Unused address bits are 0.
  - wdata = lfsr[DATA_WIDTH-1:0] XOR txn_count[DATA_WIDTH-1:0].
- WR_REQ: drive d_addr/d_wdata, d_mode=1, d_valid=1.
  - Accept on posedge with d_valid & d_ready; d_valid drops next cycle.
  - d_addr, d_wdata, d_mode stay stable until pair completion.
- WR_WAIT: wait to observe d_ready==0, then d_ready==1 (busy-then-idle) = completion. Go to RD_REQ.
- RD_REQ/RD_WAIT: same handshake with d_mode=0. d_rdata is sampled on the cycle d_ready returns to 1.
- CHECK (1 cycle):
  - Compare sampled rdata with wdata.
  - Mismatch: err_count+1; capture fail_* only if err_count was 0.
  - txn_count+1.
  - If txn_count==NUM_TXN go to DONE, else GAP (0 cycles unless feature enabled), then GEN.
- Timeout: per-phase counter. Exceeding TIMEOUT_CYCLES in a REQ or WAIT state counts 1 error, captures fail_* with fail_act=0, drops d_valid, and moves to CHECK-equivalent accounting (counts as completed pair).
- DONE: busy=0, done=1, pass=(err_count==0).
- Counters saturate at 16'hFFFF.

Optional Feature:
- Macro BUS_TGEN_RANDOM_GAP_EN.
- Defined: GAP lasts lfsr[2:0] idle cycles (0-7), sampled in CHECK, with d_valid=0. Mimics random inter-request spacing to create arbitration collisions with other masters.
- Undefined: GAP is skipped; back-to-back pairs, one GEN cycle between them.

Decomposition:
- Package bus_tgen_pkg: state enum, LFSR polynomial tap constant, MODE_READ=0 / MODE_WRITE=1 constants.
- Sub-module bus_tgen_lfsr: 16-bit Fibonacci LFSR with seed, enable, synchronous reset; instantiated once.

Test Plan:
- Bench slave model: ready drops 1 cycle after accept, returns 3 cycles later, memory echo. NUM_TXN=4, start -> 8 accepts alternating mode 1/0; done=1, pass=1, err_count=0, txn_count=4.
- Model corrupts read data bit 0 on pair 2 -> err_count=1, pass=0, fail_addr equals pair-2 address, fail_act = fail_exp ^ 8'h01.
- d_ready held 0 forever, TIMEOUT_CYCLES=8 -> each phase times out; run completes, err_count=NUM_TXN, done=1.
- Assert rst during RD_WAIT -> next edge d_valid=0, busy=0, counters 0; a new start reruns with the same address sequence (seed reload).
- NUM_SLAVES=3: every issued d_addr has id<=2; id 0 addresses have bits [11] clear.
- With BUS_TGEN_RANDOM_GAP_EN, two instances on top d1/d2 -> both pass=1 under contention; gap lengths vary 0-7.
